// File: rtl/tick_timeout_tracker.sv
// Per-slot tick-driven timeout tracker: arm loads a budget, ticks count it down,
// and exhaustion raises a sticky expired flag until the slot is cleared.
module tick_timeout_tracker #(
    parameter int NumSlots = 4,
    parameter int CntWidth = 10,
    parameter int IdxW     = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                arm_valid_i,
    output logic                arm_ready_o,
    input  logic [IdxW-1:0]     arm_id_i,
    input  logic [CntWidth-1:0] arm_budget_i,
    input  logic                clear_valid_i,
    input  logic [IdxW-1:0]     clear_id_i,
    output logic [NumSlots-1:0] busy_o,
    output logic [NumSlots-1:0] expired_o,
    output logic                timeout_pulse_o,
    output logic                irq_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } slot_state_e;

    slot_state_e         state_q [NumSlots];
    slot_state_e         state_d [NumSlots];
    logic [CntWidth-1:0] cnt_q   [NumSlots];
    logic [CntWidth-1:0] cnt_d   [NumSlots];
    logic                pulse_q, pulse_d;
    logic [NumSlots-1:0] arm_hit, clr_hit;

    // Ready is decoded from the pre-clear state, so a same-slot clear never enables an arm.
    always_comb begin
        arm_ready_o = 1'b0;
        for (int n = 0; n < NumSlots; n++) begin
            if (arm_id_i == IdxW'(n) && state_q[n] == S_IDLE) begin
                arm_ready_o = 1'b1;
            end
        end
    end

    always_comb begin
        pulse_d = 1'b0;
        arm_hit = '0;
        clr_hit = '0;
        for (int n = 0; n < NumSlots; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            arm_hit[n] = arm_valid_i && arm_ready_o && (arm_id_i == IdxW'(n));
            clr_hit[n] = clear_valid_i && (clear_id_i == IdxW'(n));
            case (state_q[n])
                S_IDLE: begin
                    if (arm_hit[n]) begin
                        state_d[n] = S_COUNT;
                        cnt_d[n]   = arm_budget_i;
                    end
                end
                S_COUNT: begin
                    // Clear wins over the expiring tick.
                    if (clr_hit[n]) begin
                        state_d[n] = S_IDLE;
                        cnt_d[n]   = '0;
                    end else if (tick_i) begin
                        if (cnt_q[n] == '0) begin
                            state_d[n] = S_EXPIRED;
                            pulse_d    = 1'b1;
                        end else begin
                            cnt_d[n] = cnt_q[n] - 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    if (clr_hit[n]) begin
                        state_d[n] = S_IDLE;
                        cnt_d[n]   = '0;
                    end
                end
                default: begin
                    state_d[n] = S_IDLE;
                    cnt_d[n]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_q <= 1'b0;
            for (int n = 0; n < NumSlots; n++) begin
                state_q[n] <= S_IDLE;
                cnt_q[n]   <= '0;
            end
        end else begin
            pulse_q <= pulse_d;
            for (int n = 0; n < NumSlots; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    always_comb begin
        busy_o    = '0;
        expired_o = '0;
        for (int n = 0; n < NumSlots; n++) begin
            busy_o[n]    = (state_q[n] == S_COUNT);
            expired_o[n] = (state_q[n] == S_EXPIRED);
        end
    end

    assign timeout_pulse_o = pulse_q;
    assign irq_o           = |expired_o;

endmodule
